// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder slice.
//   - MMIO region base address and per-register byte offsets
//   - control_uart access encodings
//   - TX holding-buffer state encoding
package mmio_responder_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  // Only the low byte of the address is decoded inside the region.
  localparam logic [7:0] OFF_STATUS   = 8'h00;
  localparam logic [7:0] OFF_RX_DATA  = 8'h04;
  localparam logic [7:0] OFF_TX_DATA  = 8'h08;
  localparam logic [7:0] OFF_CYC_CNT  = 8'h10;
  localparam logic [7:0] OFF_INST_CNT = 8'h14;
  localparam logic [7:0] OFF_CNT_RST  = 8'h18;

  // control_uart encodings; 2'b00 and 2'b11 mean no access.
  localparam logic [1:0] MMIO_LD = 2'b01;
  localparam logic [1:0] MMIO_ST = 2'b10;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/mmio_responder_counter.sv
// mmio_counter: width-parameterised free-running counter.
//   clk, rst : clock and synchronous active-high reset
//   clear    : synchronous clear; takes priority over en
//   en       : increment by one this cycle
//   count    : current value, wraps modulo 2^WIDTH
module mmio_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is always updated with non-blocking assignments
  // so every register samples its inputs from before the edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: MMIO slave for the 0x8000_00xx region on the data side.
//   clk, rst          : core clock, synchronous active-high reset
//   addr_i            : byte address (only [7:0] decoded)
//   wdata_i, we_i     : lane-aligned store data and byte enables
//   control_uart_i    : 01 = load, 10 = store, other = idle
//   stall_i           : holds rdata_o
//   inst_retire_i     : one instruction retired this cycle
//   rdata_o           : load data, one cycle after the request
//   uart_tx_*         : one-entry transmit holding buffer handshake
//   uart_rx_*         : receive byte interface; rx_ready pops a byte
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int CLOCK_COUNTER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  we_i,
  input  logic [1:0]  control_uart_i,
  input  logic        stall_i,
  input  logic        inst_retire_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  uart_tx_data_o,
  output logic        uart_tx_valid_o,
  input  logic        uart_tx_ready_i,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_rx_valid_i,
  output logic        uart_rx_ready_o
);

  logic [7:0] offset;
  logic       is_load;
  logic       is_store;
  logic       status_load;
  logic       tx_store;
  logic       tx_drop;
  logic       cnt_clear;
  logic [31:0] read_data;

  tx_state_t  tx_state;
  logic       tx_overrun;

  logic [CLOCK_COUNTER_WIDTH-1:0] cycle_cnt;
  logic [CLOCK_COUNTER_WIDTH-1:0] inst_cnt;

  // Upper address/data bits are outside the decoded window.
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:8], wdata_i[31:8]};

  assign offset      = addr_i[7:0];
  assign is_load     = (control_uart_i == MMIO_LD);
  // A store with no byte enables is a no-op everywhere.
  assign is_store    = (control_uart_i == MMIO_ST) && (we_i != 4'b0000);
  assign status_load = is_load && (offset == OFF_STATUS);
  assign tx_store    = is_store && (offset == OFF_TX_DATA) && we_i[0];
  // Includes the handoff cycle: the slot is not free until the next edge.
  assign tx_drop     = tx_store && (tx_state == TX_FULL);
  assign cnt_clear   = is_store && (offset == OFF_CNT_RST);

  // Pop only when a byte is actually present.
  assign uart_rx_ready_o = is_load && (offset == OFF_RX_DATA) && uart_rx_valid_i;

  assign uart_tx_valid_o = (tx_state == TX_FULL);

  mmio_counter #(.WIDTH(CLOCK_COUNTER_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (1'b1),
    .count (cycle_cnt)
  );

  mmio_counter #(.WIDTH(CLOCK_COUNTER_WIDTH)) u_inst_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (inst_retire_i),
    .count (inst_cnt)
  );

  // NOTE: the default assignment before the case keeps this block free of
  // inferred latches for unmapped offsets.
  always_comb begin
    read_data = '0;
    case (offset)
      OFF_STATUS:   read_data = {29'b0, tx_overrun, uart_rx_valid_i,
                                 (tx_state == TX_EMPTY)};
      OFF_RX_DATA:  read_data = {24'b0, uart_rx_data_i};
      OFF_CYC_CNT:  read_data = 32'(cycle_cnt);
      OFF_INST_CNT: read_data = 32'(inst_cnt);
      default:      read_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_o        <= '0;
      tx_state       <= TX_EMPTY;
      uart_tx_data_o <= '0;
      tx_overrun     <= 1'b0;
    end else begin
      if (!stall_i) begin
        rdata_o <= is_load ? read_data : '0;
      end

      case (tx_state)
        TX_EMPTY: begin
          if (tx_store) begin
            uart_tx_data_o <= wdata_i[7:0];
            tx_state       <= TX_FULL;
          end
        end
        TX_FULL: begin
          if (uart_tx_ready_i) begin
            tx_state <= TX_EMPTY;
          end
        end
        default: tx_state <= TX_EMPTY;
      endcase

      // A same-cycle drop beats the read-to-clear.
      if (tx_drop) begin
        tx_overrun <= 1'b1;
      end else if (status_load) begin
        tx_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;
  import mmio_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  we_i;
  logic [1:0]  control_uart_i;
  logic        stall_i;
  logic        inst_retire_i;
  logic [31:0] rdata_o;
  logic [7:0]  uart_tx_data_o;
  logic        uart_tx_valid_o;
  logic        uart_tx_ready_i;
  logic [7:0]  uart_rx_data_i;
  logic        uart_rx_valid_i;
  logic        uart_rx_ready_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state, kept as plain numbers derived from the register map.
  logic [31:0] m_rdata;
  bit          m_tx_full;
  logic [7:0]  m_tx_data;
  bit          m_ovr;
  int unsigned m_cyc;
  int unsigned m_inst;

  mmio_responder #(.CLOCK_COUNTER_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .we_i            (we_i),
    .control_uart_i  (control_uart_i),
    .stall_i         (stall_i),
    .inst_retire_i   (inst_retire_i),
    .rdata_o         (rdata_o),
    .uart_tx_data_o  (uart_tx_data_o),
    .uart_tx_valid_o (uart_tx_valid_o),
    .uart_tx_ready_i (uart_tx_ready_i),
    .uart_rx_data_i  (uart_rx_data_i),
    .uart_rx_valid_i (uart_rx_valid_i),
    .uart_rx_ready_o (uart_rx_ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    control_uart_i = 2'b00;
    addr_i         = '0;
    wdata_i        = '0;
    we_i           = '0;
  endtask

  // One clock: predict from the current inputs, cross the edge, compare.
  task automatic cycle();
    bit          ld, st, tx_st, status_ld, clr, exp_ready;
    logic [7:0]  off;
    logic [31:0] rd;
    #1;
    ld        = (control_uart_i == 2'b01);
    st        = (control_uart_i == 2'b10) && (we_i != 0);
    off       = addr_i[7:0];
    tx_st     = st && off == 8'h08 && we_i[0];
    status_ld = ld && off == 8'h00;
    clr       = st && off == 8'h18;
    exp_ready = ld && off == 8'h04 && uart_rx_valid_i;
    check("rx_ready", {31'b0, uart_rx_ready_o}, {31'b0, exp_ready});
    case (off)
      8'h00:   rd = {29'b0, m_ovr, uart_rx_valid_i, !m_tx_full};
      8'h04:   rd = {24'b0, uart_rx_data_i};
      8'h10:   rd = m_cyc;
      8'h14:   rd = m_inst;
      default: rd = 0;
    endcase
    @(posedge clk);
    if (rst) begin
      m_rdata = 0; m_tx_full = 0; m_tx_data = 0; m_ovr = 0; m_cyc = 0; m_inst = 0;
    end else begin
      if (!stall_i) m_rdata = ld ? rd : 0;
      if (m_tx_full && tx_st) m_ovr = 1;
      else if (status_ld) m_ovr = 0;
      if (m_tx_full) begin
        if (uart_tx_ready_i) m_tx_full = 0;
      end else if (tx_st) begin
        m_tx_full = 1;
        m_tx_data = wdata_i[7:0];
      end
      if (clr) begin
        m_cyc = 0; m_inst = 0;
      end else begin
        m_cyc  = m_cyc + 1;
        m_inst = m_inst + (inst_retire_i ? 1 : 0);
      end
    end
    #1;
    check("rdata", rdata_o, m_rdata);
    check("tx_valid", {31'b0, uart_tx_valid_o}, {31'b0, m_tx_full});
    check("tx_data", {24'b0, uart_tx_data_o}, {24'b0, m_tx_data});
  endtask

  task automatic req(input logic [1:0] ctl, input logic [7:0] off,
                     input logic [31:0] wd, input logic [3:0] we);
    control_uart_i = ctl;
    addr_i         = MMIO_BASE | {24'b0, off};
    wdata_i        = wd;
    we_i           = we;
    cycle();
    idle_inputs();
  endtask

  initial begin
    logic [7:0] offs [8];
    offs = '{OFF_STATUS, OFF_RX_DATA, OFF_TX_DATA, OFF_CYC_CNT,
             OFF_INST_CNT, OFF_CNT_RST, 8'h0C, 8'h3C};

    idle_inputs();
    rst = 1'b1; stall_i = 0; inst_retire_i = 0;
    uart_tx_ready_i = 0; uart_rx_data_i = 0; uart_rx_valid_i = 0;
    m_rdata = 0; m_tx_full = 0; m_tx_data = 0; m_ovr = 0; m_cyc = 0; m_inst = 0;
    cycle();
    cycle();
    rst = 1'b0;
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_tx_valid", {31'b0, uart_tx_valid_o}, 32'h0);

    // Status after reset: TX empty only.
    req(MMIO_LD, OFF_STATUS, 0, 0);
    check("status_idle", rdata_o, 32'h1);

    // TX fill, overrun, read-to-clear.
    req(MMIO_ST, OFF_TX_DATA, 32'h41, 4'b0001);
    check("tx_valid_set", {31'b0, uart_tx_valid_o}, 32'h1);
    check("tx_data_41", {24'b0, uart_tx_data_o}, 32'h41);
    req(MMIO_ST, OFF_TX_DATA, 32'h42, 4'b0001);
    check("tx_data_kept", {24'b0, uart_tx_data_o}, 32'h41);
    req(MMIO_LD, OFF_STATUS, 0, 0);
    check("status_overrun", rdata_o, 32'h4);
    req(MMIO_LD, OFF_STATUS, 0, 0);
    check("status_ovr_clear", rdata_o, 32'h0);

    // Handoff.
    uart_tx_ready_i = 1;
    cycle();
    uart_tx_ready_i = 0;
    check("tx_valid_drop", {31'b0, uart_tx_valid_o}, 32'h0);
    req(MMIO_LD, OFF_STATUS, 0, 0);
    check("status_empty", rdata_o, 32'h1);

    // Store with no byte enables does nothing.
    req(MMIO_ST, OFF_TX_DATA, 32'h77, 4'b0000);
    check("we0_noop", {31'b0, uart_tx_valid_o}, 32'h0);

    // RX pop.
    uart_rx_valid_i = 1; uart_rx_data_i = 8'h5A;
    control_uart_i = MMIO_LD; addr_i = MMIO_BASE | 32'h04;
    #1 check("rx_ready_hi", {31'b0, uart_rx_ready_o}, 32'h1);
    cycle();
    idle_inputs();
    check("rx_data", rdata_o, 32'h5A);
    uart_rx_valid_i = 0;
    control_uart_i = MMIO_LD; addr_i = MMIO_BASE | 32'h04;
    #1 check("rx_ready_lo", {31'b0, uart_rx_ready_o}, 32'h0);
    cycle();
    idle_inputs();

    // Counters: 100 cycles after reset, 37 retiring.
    rst = 1; cycle(); rst = 0;
    for (int i = 0; i < 100; i++) begin
      inst_retire_i = (i < 37);
      cycle();
    end
    inst_retire_i = 0;
    req(MMIO_LD, OFF_CYC_CNT, 0, 0);
    check("cyc_100", rdata_o, 32'd100);
    req(MMIO_LD, OFF_INST_CNT, 0, 0);
    check("inst_37", rdata_o, 32'd37);
    inst_retire_i = 1;
    req(MMIO_ST, OFF_CNT_RST, 32'hFFFF_FFFF, 4'b1111);
    inst_retire_i = 0;
    for (int i = 0; i < 5; i++) cycle();
    req(MMIO_LD, OFF_CYC_CNT, 0, 0);
    check("cyc_after_clr", rdata_o, 32'd5);
    req(MMIO_LD, OFF_INST_CNT, 0, 0);
    check("inst_after_clr", rdata_o, 32'd0);

    // Reset with TX full and overrun pending.
    req(MMIO_ST, OFF_TX_DATA, 32'h11, 4'b0001);
    req(MMIO_ST, OFF_TX_DATA, 32'h22, 4'b0001);
    rst = 1; cycle(); rst = 0;
    check("rst_tx_valid", {31'b0, uart_tx_valid_o}, 32'h0);
    req(MMIO_LD, OFF_CYC_CNT, 0, 0);
    check("rst_cyc", rdata_o, 32'h0);
    req(MMIO_LD, OFF_INST_CNT, 0, 0);
    check("rst_inst", rdata_o, 32'h0);
    req(MMIO_LD, OFF_STATUS, 0, 0);
    check("rst_status", rdata_o, 32'h1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 99) == 0);
      control_uart_i  = rst ? 2'b00 : 2'($urandom_range(0, 3));
      addr_i          = MMIO_BASE | {24'b0, offs[$urandom_range(0, 7)]};
      wdata_i         = $urandom;
      we_i            = 4'($urandom);
      stall_i         = ($urandom_range(0, 4) == 0);
      inst_retire_i   = 1'($urandom);
      uart_tx_ready_i = ($urandom_range(0, 2) == 0);
      uart_rx_valid_i = 1'($urandom);
      uart_rx_data_i  = 8'($urandom);
      cycle();
    end
    rst = 0; stall_i = 0;
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
